// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
//  Module   : conv3x3_stream
//  Purpose  : Streaming 3x3 signed convolution over a raster pixel stream.
//             Two internal line buffers and a 3x3 window feed a two-stage
//             pipeline of nine masked products, then sum, shift, |x|, clamp.
//             Borders are zero-padded by masking taps from centre coordinates.
//  Revision : 1.0  initial release
// ============================================================================
module conv3x3_stream #(
    parameter int PIX_W  = 12,
    parameter int OUT_W  = 12,
    parameter int COEF_W = 4,
    parameter int IMG_W  = 1280,
    parameter int IMG_H  = 960
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_data,
    input  logic              coef_wr,
    input  logic [3:0]        coef_idx,
    input  logic [COEF_W-1:0] coef_data,
    input  logic [3:0]        shift,
    input  logic              abs_en,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic [10:0]       out_x,
    output logic [10:0]       out_y,
    output logic              frame_done
);
    localparam int          c_PROD_W    = PIX_W + COEF_W + 1;
    localparam int          c_SUM_W     = PIX_W + COEF_W + 5;
    localparam int          c_AW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_RUN    = 2'd1;
    localparam logic [1:0]  c_ST_FLUSH  = 2'd2;
    localparam logic [10:0] c_LAST_COL  = 11'(IMG_W - 1);
    localparam logic [11:0] c_LAST_ROW  = 12'(IMG_H - 1);
    localparam logic [11:0] c_FLUSH_ROW = 12'(IMG_H + 1);
    localparam logic [10:0] c_LAST_CY   = 11'(IMG_H - 1);

    logic [1:0]  r_state;
    logic        r_in_ready;
    logic [10:0] r_col;
    logic [11:0] r_row;
    logic [3:0]  r_shift;
    logic        r_abs;

    logic [PIX_W-1:0] r_lb1 [IMG_W];
    logic [PIX_W-1:0] r_lb2 [IMG_W];
    logic [PIX_W-1:0] r_win [3][3];

    logic        r_s0_valid, r_s0_last;
    logic [10:0] r_s0_x, r_s0_y;
    logic signed [c_PROD_W-1:0] r_prod [9];
    logic        r_s1_valid, r_s1_last;
    logic [10:0] r_s1_x, r_s1_y;

    logic                       w_accept, w_slot, w_latch, w_cvalid;
    logic [PIX_W-1:0]           w_pix;
    logic [c_AW-1:0]            w_addr;
    logic [10:0]                w_cx, w_cy;
    logic [2:0]                 w_row_ok, w_col_ok;
    logic signed [COEF_W-1:0]   w_coef [9];
    logic signed [c_PROD_W-1:0] w_prod [9];
    logic signed [c_SUM_W-1:0]  w_sum, w_shifted, w_mag;
    logic [OUT_W-1:0]           w_clamped;

    // A slot is either an accepted pixel or an injected zero while flushing.
    assign w_accept = in_valid && r_in_ready;
    assign w_slot   = w_accept || (r_state == c_ST_FLUSH);
    assign w_latch  = w_accept && (r_state == c_ST_IDLE);
    assign w_pix    = (r_state == c_ST_FLUSH) ? '0 : in_data;
    assign w_addr   = r_col[c_AW-1:0];
    assign in_ready = r_in_ready;

    // Centre of the window after this slot: one column/row behind the slot,
    // except column 0 whose centre is the last column two rows back.
    always_comb begin
        w_cx     = '0;
        w_cy     = '0;
        w_cvalid = 1'b0;
        if (r_col == '0) begin
            w_cx     = c_LAST_COL;
            w_cy     = 11'(r_row - 12'd2);
            w_cvalid = (r_row >= 12'd2);
        end else begin
            w_cx     = r_col - 11'd1;
            w_cy     = 11'(r_row - 12'd1);
            w_cvalid = (r_row >= 12'd1);
        end
    end

    // Frame FSM and slot position counters; flush row runs past the image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_in_ready <= 1'b1;
            r_col      <= '0;
            r_row      <= '0;
        end else if (w_slot) begin
            if (r_state == c_ST_FLUSH && r_col == '0 && r_row == c_FLUSH_ROW) begin
                r_state    <= c_ST_IDLE;
                r_in_ready <= 1'b1;
                r_col      <= '0;
                r_row      <= '0;
            end else begin
                if (r_col == c_LAST_COL) begin
                    r_col <= '0;
                    r_row <= r_row + 12'd1;
                end else begin
                    r_col <= r_col + 11'd1;
                end
                if (r_state != c_ST_FLUSH) begin
                    if (r_col == c_LAST_COL && r_row == c_LAST_ROW) begin
                        r_state    <= c_ST_FLUSH;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_state <= c_ST_RUN;
                    end
                end
            end
        end
    end

    // Shift and magnitude mode are frozen for the whole frame at its first pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_abs   <= 1'b0;
        end else if (w_latch) begin
            r_shift <= shift;
            r_abs   <= abs_en;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_coef
            logic                     w_hit;
            logic signed [COEF_W-1:0] r_shadow;
            logic signed [COEF_W-1:0] r_active;
            assign w_hit      = coef_wr && (coef_idx == 4'(gi));
            assign w_coef[gi] = r_active;
            // Shadow takes writes any time; a write coinciding with the latch wins.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shadow <= '0;
                    r_active <= '0;
                end else begin
                    if (w_hit) r_shadow <= coef_data;
                    if (w_latch) r_active <= w_hit ? coef_data : r_shadow;
                end
            end
        end
    endgenerate

    // Line buffers and window advance only on slots; their contents need no
    // reset because every stale tap is masked by the centre coordinates.
    always_ff @(posedge clk) begin
        if (w_slot) begin
            r_lb1[w_addr] <= w_pix;
            r_lb2[w_addr] <= r_lb1[w_addr];
            r_win[0][0]   <= r_win[0][1];
            r_win[0][1]   <= r_win[0][2];
            r_win[0][2]   <= r_lb2[w_addr];
            r_win[1][0]   <= r_win[1][1];
            r_win[1][1]   <= r_win[1][2];
            r_win[1][2]   <= r_lb1[w_addr];
            r_win[2][0]   <= r_win[2][1];
            r_win[2][1]   <= r_win[2][2];
            r_win[2][2]   <= w_pix;
        end
    end

    // Window-stage tags: centre coordinates, valid and last-of-frame flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
            r_s0_x     <= '0;
            r_s0_y     <= '0;
        end else begin
            r_s0_valid <= w_slot && w_cvalid;
            r_s0_last  <= w_slot && w_cvalid && (w_cx == c_LAST_COL) && (w_cy == c_LAST_CY);
            if (w_slot) begin
                r_s0_x <= w_cx;
                r_s0_y <= w_cy;
            end
        end
    end

    // Bit 0 is the top row / left column of the window.
    assign w_row_ok = {(r_s0_y != c_LAST_CY), 1'b1, (r_s0_y != '0)};
    assign w_col_ok = {(r_s0_x != c_LAST_COL), 1'b1, (r_s0_x != '0)};

    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            localparam int c_R = gi / 3;
            localparam int c_C = gi % 3;
            logic signed [c_PROD_W-1:0] w_a, w_b;
            assign w_a = $signed({{COEF_W{1'b0}}, 1'b0, r_win[c_R][c_C]});
            assign w_b = $signed({{(PIX_W + 1){w_coef[gi][COEF_W-1]}}, w_coef[gi]});
            assign w_prod[gi] = (w_row_ok[c_R] && w_col_ok[c_C]) ? w_a * w_b : '0;
        end
    endgenerate

    // Stage 1: register the nine masked products with their tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod     <= '{default: '0};
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
        end else begin
            r_prod     <= w_prod;
            r_s1_valid <= r_s0_valid;
            r_s1_last  <= r_s0_last;
            r_s1_x     <= r_s0_x;
            r_s1_y     <= r_s0_y;
        end
    end

    // Sum is wide enough that nine worst-case products cannot overflow;
    // the saturation slice assumes the sum is wider than the output.
    always_comb begin
        w_sum = c_SUM_W'(r_prod[0]) + c_SUM_W'(r_prod[1]) + c_SUM_W'(r_prod[2])
              + c_SUM_W'(r_prod[3]) + c_SUM_W'(r_prod[4]) + c_SUM_W'(r_prod[5])
              + c_SUM_W'(r_prod[6]) + c_SUM_W'(r_prod[7]) + c_SUM_W'(r_prod[8]);
        w_shifted = w_sum >>> r_shift;
        w_mag     = (r_abs && w_shifted[c_SUM_W-1]) ? -w_shifted : w_shifted;
        if (w_mag[c_SUM_W-1])
            w_clamped = '0;
        else if (|w_mag[c_SUM_W-2:OUT_W])
            w_clamped = '1;
        else
            w_clamped = w_mag[OUT_W-1:0];
    end

    // Stage 2: registered result, coordinates and end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_x      <= '0;
            out_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= r_s1_valid;
            frame_done <= r_s1_last;
            if (r_s1_valid) begin
                out_data <= w_clamped;
                out_x    <= r_s1_x;
                out_y    <= r_s1_y;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv3x3_stream
//  Purpose  : Self-checking bench for conv3x3_stream on a 4x3 image.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv3x3_stream;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        coef_wr;
    logic [3:0]  coef_idx;
    logic [3:0]  coef_data;
    logic [3:0]  shift;
    logic        abs_en;
    logic        out_valid;
    logic [11:0] out_data;
    logic [10:0] out_x;
    logic [10:0] out_y;
    logic        frame_done;

    conv3x3_stream #(
        .PIX_W(12), .OUT_W(12), .COEF_W(4), .IMG_W(W), .IMG_H(H)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_wr(coef_wr), .coef_idx(coef_idx), .coef_data(coef_data),
        .shift(shift), .abs_en(abs_en),
        .out_valid(out_valid), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct { int data; int x; int y; bit last; int cyc; } exp_t;
    typedef struct { int at; int idx; int data; } wr_t;
    typedef struct {
        int kid; int sh; int ab; int base; int sx; int sy;
        int e_corner; int e_edge; int e_int;
    } vec_t;

    exp_t sbq[$];
    wr_t  wrq[$];
    vec_t vecs[7];
    int   kerns[4][9];
    int   obs[N];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_pix(input int base, sx, sy, x, y);
        return base + sx * x + sy * y;
    endfunction

    // Direct 3x3 definition with zero padding, shift, optional magnitude, clamp.
    function automatic int ref_conv(input int kid, base, sx, sy, sh, ab, cx, cy);
        int s = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (cx + dx >= 0 && cx + dx < W && cy + dy >= 0 && cy + dy < H)
                    s += kerns[kid][(dy + 1) * 3 + dx + 1] * ref_pix(base, sx, sy, cx + dx, cy + dy);
        s = s >>> sh;
        if (ab != 0 && s < 0) s = -s;
        if (s < 0) s = 0;
        if (s > 4095) s = 4095;
        return s;
    endfunction

    // Output monitor: pops the scoreboard on every out_valid.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = sbq.pop_front();
                checks++;
                if (int'(out_data) != e.data || int'(out_x) != e.x || int'(out_y) != e.y ||
                    frame_done != e.last) begin
                    errors++;
                    $display("FAIL result(%0d,%0d): got data=%0d x=%0d y=%0d done=%0b, expected data=%0d done=%0b",
                             e.x, e.y, out_data, out_x, out_y, frame_done, e.data, e.last);
                end
                chk("latency", cyc - e.cyc, 2);
                if (int'(out_x) < W && int'(out_y) < H)
                    obs[int'(out_y) * W + int'(out_x)] = int'(out_data);
            end
        end else if (frame_done) begin
            chk("frame_done_without_valid", 1, 0);
        end
    end

    task automatic prog(input int kid);
        for (int i = 0; i < 9; i++) begin
            coef_wr   = 1'b1;
            coef_idx  = 4'(i);
            coef_data = 4'(kerns[kid][i]);
            @(posedge clk);
            #1;
        end
        coef_wr = 1'b0;
    endtask

    // Drive one frame; expected results use kernel kid as the active set.
    task automatic run_frame(input int kid, base, sx, sy, sh, ab, input bit gaps);
        int last_cyc = 0;
        int low = 0;
        int waitc = 0;
        shift  = 4'(sh);
        abs_en = ab[0];
        for (int i = 0; i < N; i++) obs[i] = -1;
        for (int n = 0; n < N; n++) begin
            bit acc = 1'b0;
            bit rdy;
            int c;
            if (gaps) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = 12'(ref_pix(base, sx, sy, n % W, n / W));
            if (wrq.size() > 0 && wrq[0].at == n) begin
                coef_wr   = 1'b1;
                coef_idx  = 4'(wrq[0].idx);
                coef_data = 4'(wrq[0].data);
                void'(wrq.pop_front());
            end
            for (int t = 0; t < 8 && !acc; t++) begin
                rdy = in_ready;
                @(posedge clk);
                #1;
                acc = rdy;
            end
            coef_wr  = 1'b0;
            in_valid = 1'b0;
            if (!acc) begin
                chk("accept_timeout", 0, 1);
                return;
            end
            last_cyc = cyc;
            if (n >= W + 1) begin
                c = n - W - 1;
                sbq.push_back('{ref_conv(kid, base, sx, sy, sh, ab, c % W, c / W),
                                c % W, c / W, (c == N - 1), cyc});
            end
        end
        for (int c = N - W - 1; c < N; c++)
            sbq.push_back('{ref_conv(kid, base, sx, sy, sh, ab, c % W, c / W),
                            c % W, c / W, (c == N - 1), last_cyc + 1 + (c - (N - W - 1))});
        while (!in_ready && low < 50) begin
            low++;
            @(posedge clk);
            #1;
        end
        chk("flush_ready_low_cycles", low, W + 1);
        while (sbq.size() != 0 && waitc < 30) begin
            waitc++;
            @(posedge clk);
            #1;
        end
        chk("frame_drained", sbq.size(), 0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        kerns[0] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        kerns[1] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        kerns[2] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        kerns[3] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
        //            kid sh ab base   sx  sy  corner edge  int
        vecs[0] = '{0,  0, 0,    0,   1,  4,     0,    1,    5};
        vecs[1] = '{1,  0, 0,   10,   0,  0,    40,   60,   90};
        vecs[2] = '{1,  0, 0, 4095,   0,  0,  4095, 4095, 4095};
        vecs[3] = '{1,  3, 0, 4095,   0,  0,  2047, 3071, 4095};
        vecs[4] = '{2,  0, 0,    0, 100,  0,   300,  600,  800};
        vecs[5] = '{3,  0, 0,    0, 100,  0,     0,    0,    0};
        vecs[6] = '{3,  0, 1,    0, 100,  0,   300,  600,  800};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; coef_wr = 1'b0;
        coef_idx = '0; coef_data = '0; shift = '0; abs_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_out_xy", int'(out_x) + int'(out_y), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            prog(vecs[v].kid);
            run_frame(vecs[v].kid, vecs[v].base, vecs[v].sx, vecs[v].sy,
                      vecs[v].sh, vecs[v].ab, 1'b0);
            chk($sformatf("vec%0d_corner", v), obs[0], vecs[v].e_corner);
            chk($sformatf("vec%0d_edge", v), obs[1], vecs[v].e_edge);
            chk($sformatf("vec%0d_interior", v), obs[W + 1], vecs[v].e_int);
        end

        // Mid-frame shadow rewrite to identity: this frame stays all-ones.
        prog(1);
        for (int i = 0; i < 9; i++) wrq.push_back('{3 + i, i, kerns[0][i]});
        run_frame(1, 0, 1, 4, 0, 0, 1'b0);
        chk("midwrite_old_kernel_interior", obs[W + 1], 45);
        // Next frame picks up identity, with in_valid toggling.
        run_frame(0, 0, 1, 4, 0, 0, 1'b1);
        chk("gapped_identity_interior", obs[W + 1], 5);

        // Reset after 6 accepted pixels of a partial frame.
        prog(1);
        for (int n = 0; n < 6; n++) begin
            in_valid = 1'b1;
            in_data  = 12'd7;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_out_xy", int'(out_x) + int'(out_y), 0);
        chk("midrst_frame_done", int'(frame_done), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Shadow is zero after reset; centre tap written with the first pixel.
        wrq.push_back('{0, 4, 1});
        run_frame(0, 0, 1, 4, 0, 0, 1'b0);
        chk("post_reset_last", obs[N - 1], 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
